mem_access_unit: RTL and testbench

- Sits between the execute stage and the data memory port. Accepts one load/store per transaction.
- Generates word-aligned address, byte enables and lane-replicated store data, and runs the request/grant/rvalid handshake with data memory.
- Extracts, sign-extends or zero-extends load data, then presents it to writeback.
- Holds off the pipeline while an access is outstanding. Only one access is in flight at a time.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - execute-side request, data-memory port and writeback signals
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        access_fault;
  logic        bus_err;
  logic        stall;

  modport slave (
    input  req_valid, opcode, funct3, addr, store_data,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output resp_valid, resp_data, access_fault, bus_err, stall
  );

  modport master (
    output req_valid, opcode, funct3, addr, store_data,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  resp_valid, resp_data, access_fault, bus_err, stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with req/gnt/rvalid handshake
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        berr_q, berr_d;

  logic        is_load, is_store, f3_ok, align_ok, tmo_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ext_data;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    is_load  = (bus.opcode == OP_LOAD);
    is_store = (bus.opcode == OP_STORE);
    f3_ok    = 1'b0;
    if (is_load)
      f3_ok = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (is_store)
      f3_ok = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
    // funct3[1:0] encodes size for both loads and stores
    case (bus.funct3[1:0])
      2'b01:   align_ok = ~bus.addr[0];
      2'b10:   align_ok = (bus.addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    be_new    = 4'b1111;
    wdata_new = bus.store_data;
    if (is_store) begin
      case (bus.funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << bus.addr[1:0];
          wdata_new = {4{bus.store_data[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << bus.addr[1:0];
          wdata_new = {2{bus.store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'b00:   b = bus.dmem_rdata[7:0];
      2'b01:   b = bus.dmem_rdata[15:8];
      2'b10:   b = bus.dmem_rdata[23:16];
      default: b = bus.dmem_rdata[31:24];
    endcase
    h = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_data = {{24{b[7]}}, b};
      3'b100:  ext_data = {24'd0, b};
      3'b001:  ext_data = {{16{h[15]}}, h};
      3'b101:  ext_data = {16'd0, h};
      default: ext_data = bus.dmem_rdata;
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && (is_load || is_store)) begin
          if (f3_ok && align_ok) begin
            state_d = REQ;
            cnt_d   = '0;
            f3_d    = bus.funct3;
            off_d   = bus.addr[1:0];
            we_d    = is_store;
            be_d    = be_new;
            addr_d  = {bus.addr[31:2], 2'b00};
            wdata_d = wdata_new;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        // grant takes priority over a timeout expiring in the same cycle
        if (bus.dmem_gnt) begin
          state_d = we_q ? RESP : WAIT;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = IDLE;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid) begin
          state_d = RESP;
          rdata_d = ext_data;
        end else if (tmo_hit) begin
          state_d = IDLE;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.stall        = (state_q != IDLE);
  assign bus.dmem_req     = (state_q == REQ);
  assign bus.dmem_we      = we_q;
  assign bus.dmem_be      = be_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_data    = rdata_q;
  assign bus.access_fault = fault_q;
  assign bus.bus_err      = berr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  mem_access_unit #(.TIMEOUT_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] resp;
  } vec_t;

  vec_t        vt[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_resp = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic do_access(input vec_t v);
    issue(v.op, v.f3, v.addr, v.sd);
    @(negedge clk);
    if (v.fault) begin
      chk("fault_pulse", 32'(bus.access_fault), 32'd1);
      chk("fault_no_req", 32'(bus.dmem_req), 32'd0);
      chk("fault_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      chk("fault_one_cycle", 32'(bus.access_fault), 32'd0);
      chk("fault_no_req2", 32'(bus.dmem_req), 32'd0);
      return;
    end
    chk("req", 32'(bus.dmem_req), 32'd1);
    chk("ready_busy", 32'(bus.req_ready), 32'd0);
    chk("stall", 32'(bus.stall), 32'd1);
    chk("daddr", bus.dmem_addr, v.daddr);
    chk("be", 32'(bus.dmem_be), 32'(v.be));
    chk("we", 32'(bus.dmem_we), (v.op == ST) ? 32'd1 : 32'd0);
    if (v.op == ST) chk("wdata", bus.dmem_wdata, v.wdata);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk("req_drop", 32'(bus.dmem_req), 32'd0);
    if (v.op == LD) begin
      chk("no_early_resp", 32'(bus.resp_valid), 32'd0);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = v.rdata;
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'hDEAD_BEEF;
      last_resp = v.resp;
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_data", bus.resp_data, last_resp);
    @(negedge clk);
    chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    chk("ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.addr = '0;
    bus.store_data = '0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = 32'hDEAD_BEEF;

    //        op  f3      addr          sd            rdata         flt be       daddr         wdata         resp
    vt.push_back('{ST, 3'b000, 32'h0000_1003, 32'hAABB_CC5A, 32'h0,        0, 4'b1000, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0});
    vt.push_back('{LD, 3'b000, 32'h0000_2001, 32'h0,        32'h1234_F678, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'hFFFF_FFF6});
    vt.push_back('{LD, 3'b100, 32'h0000_2001, 32'h0,        32'h1234_F678, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'h0000_00F6});
    vt.push_back('{ST, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'h0,        0, 4'b1100, 32'h0000_3000, 32'hBEEF_BEEF, 32'h0});
    vt.push_back('{LD, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'hFFFF_8001});
    vt.push_back('{LD, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'h0000_8001});
    vt.push_back('{LD, 3'b010, 32'h0000_2000, 32'h0,        32'h8001_ABCD, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'h8001_ABCD});
    vt.push_back('{ST, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'h0,        0, 4'b1111, 32'h0000_3004, 32'hCAFE_F00D, 32'h0});
    vt.push_back('{LD, 3'b000, 32'h0000_4003, 32'h0,        32'h9A00_0000, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'hFFFF_FF9A});
    vt.push_back('{LD, 3'b100, 32'h0000_4002, 32'h0,        32'h00AB_0000, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'h0000_00AB});
    vt.push_back('{LD, 3'b001, 32'h0000_4000, 32'h0,        32'hFFFF_7FFF, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'h0000_7FFF});
    vt.push_back('{ST, 3'b000, 32'h0000_4001, 32'h0000_0033, 32'h0,        0, 4'b0010, 32'h0000_4000, 32'h3333_3333, 32'h0});
    vt.push_back('{LD, 3'b010, 32'h0000_3002, 32'h0,        32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0});
    vt.push_back('{ST, 3'b001, 32'h0000_3001, 32'h0,        32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0});
    vt.push_back('{LD, 3'b011, 32'h0000_3000, 32'h0,        32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0});
    vt.push_back('{ST, 3'b100, 32'h0000_3000, 32'h0,        32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0});

    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) do_access(vt[i]);

    // unrelated opcode is ignored
    issue(7'b0110011, 3'b000, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("other_op_ready", 32'(bus.req_ready), 32'd1);
    chk("other_op_req", 32'(bus.dmem_req), 32'd0);
    chk("other_op_fault", 32'(bus.access_fault), 32'd0);

    // timeout with grant withheld
    issue(LD, 3'b010, 32'h0000_5000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tmo_req_held", 32'(bus.dmem_req), 32'd1);
      chk("tmo_no_berr", 32'(bus.bus_err), 32'd0);
    end
    @(negedge clk);
    chk("tmo_berr", 32'(bus.bus_err), 32'd1);
    chk("tmo_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("tmo_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("tmo_idle", 32'(bus.stall), 32'd0);
    chk("tmo_resp_data", bus.resp_data, last_resp);
    @(negedge clk);
    chk("tmo_berr_pulse", 32'(bus.bus_err), 32'd0);
    do_access(vt[1]);

    // grant on the expiry cycle wins over the timeout
    issue(LD, 3'b010, 32'h0000_6000, 32'h0);
    repeat (4) @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk("gnt_wins_berr", 32'(bus.bus_err), 32'd0);
    chk("gnt_wins_stall", 32'(bus.stall), 32'd1);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk("gnt_wins_resp", 32'(bus.resp_valid), 32'd1);
    chk("gnt_wins_data", bus.resp_data, 32'h0BAD_F00D);
    last_resp = 32'h0BAD_F00D;

    // asynchronous reset while waiting for read data
    issue(LD, 3'b010, 32'h0000_7000, 32'h0);
    @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk("wait_stall", 32'(bus.stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd1);
    chk("arst_resp_data", bus.resp_data, 32'h0);
    chk("arst_daddr", bus.dmem_addr, 32'h0);
    last_resp = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1111_2222;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk("late_rvalid_ignored", 32'(bus.resp_valid), 32'd0);
    chk("late_rvalid_data", bus.resp_data, 32'h0);
    chk("late_rvalid_idle", 32'(bus.stall), 32'd0);
    do_access(vt[4]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
